// File: rtl/bcd_time_display_scan.sv
// bcd_time_display_scan: scans six BCD time digits onto a multiplexed seven-segment display.
// Digits are snapshotted once per frame; the colon blinks whenever the seconds digit changes.
module bcd_time_display_scan #(
    parameter int SCAN_DIV       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_m_hr,
    input  logic [3:0] i_l_hr,
    input  logic [3:0] i_m_min,
    input  logic [3:0] i_l_min,
    input  logic [3:0] i_m_sec,
    input  logic [3:0] i_l_sec,
    input  logic       i_blank_lz,
    output logic [6:0] o_seg,
    output logic [5:0] o_an,
    output logic       o_dp,
    output logic       o_frame_start,
    output logic       o_err
);
    localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [3:0]  r_dig [6];
    logic        r_phase;
    logic        r_run;
    logic        r_err;

    logic [3:0]  w_in [6];
    logic        w_tick;
    logic        w_wrap;
    logic        w_bad;
    logic [3:0]  w_cur;
    logic [6:0]  w_dec;
    logic [6:0]  w_seg;
    logic [5:0]  w_an;
    logic        w_dp;
    logic        w_fs;

    assign w_in   = '{i_l_sec, i_m_sec, i_l_min, i_m_min, i_l_hr, i_m_hr};
    assign w_tick = r_cnt == LAST;
    assign w_wrap = w_tick && r_idx == 3'd5;
    assign w_bad  = (i_l_sec > 4'd9) | (i_m_sec > 4'd9) | (i_l_min > 4'd9) |
                    (i_m_min > 4'd9) | (i_l_hr > 4'd9) | (i_m_hr > 4'd9);
    assign w_cur  = r_dig[r_idx];

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt   <= '0;
            r_idx   <= 3'd5;
            r_phase <= 1'b1;
            r_run   <= 1'b0;
            r_err   <= 1'b0;
            for (int k = 0; k < 6; k++) r_dig[k] <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 16'd1;
            if (w_tick) r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            if (w_wrap) begin
                for (int k = 0; k < 6; k++) r_dig[k] <= w_in[k];
                r_phase <= r_phase ^ (i_l_sec != r_dig[0]);
                r_run   <= 1'b1;
                r_err   <= r_err | w_bad;
            end
        end
    end

    always_comb begin
        w_dec = 7'b1000000;
        case (w_cur)
            4'd0: w_dec = 7'b0111111;
            4'd1: w_dec = 7'b0000110;
            4'd2: w_dec = 7'b1011011;
            4'd3: w_dec = 7'b1001111;
            4'd4: w_dec = 7'b1100110;
            4'd5: w_dec = 7'b1101101;
            4'd6: w_dec = 7'b1111101;
            4'd7: w_dec = 7'b0000111;
            4'd8: w_dec = 7'b1111111;
            4'd9: w_dec = 7'b1101111;
            default: w_dec = 7'b1000000;
        endcase
    end

    // display stays dark until the first snapshot has been taken
    assign w_seg = (!r_run || (r_idx == 3'd5 && i_blank_lz && r_dig[5] == 4'd0)) ? 7'd0 : w_dec;
    assign w_an  = r_run ? 6'd1 << r_idx : 6'd0;
    assign w_dp  = r_run && r_phase && (r_idx == 3'd2 || r_idx == 3'd4);
    assign w_fs  = r_run && r_idx == 3'd0 && r_cnt == 16'd0;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_seg         <= {7{SEG_ACTIVE_LOW}};
            o_an          <= {6{SEG_ACTIVE_LOW}};
            o_dp          <= SEG_ACTIVE_LOW;
            o_frame_start <= 1'b0;
        end else begin
            o_seg         <= w_seg ^ {7{SEG_ACTIVE_LOW}};
            o_an          <= w_an ^ {6{SEG_ACTIVE_LOW}};
            o_dp          <= w_dp ^ SEG_ACTIVE_LOW;
            o_frame_start <= w_fs;
        end
    end

    assign o_err = r_err;
endmodule

// File: tb/tb_bcd_time_display_scan.sv
// tb_bcd_time_display_scan: random and directed stimulus against a frame-timeline model.
// An active-high and an active-low instance share inputs and are checked against the same model.
module tb_bcd_time_display_scan;
    localparam int D = 4;
    localparam int F = 6 * D;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       blank_lz = 1'b0;
    logic [3:0] dg [6];
    logic [6:0] seg, seg_n;
    logic [5:0] an, an_n;
    logic       dp, dp_n, fs, fs_n, err, err_n;

    logic [6:0] seg_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                 7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
                                 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

    int         vec = 0;
    int         bad = 0;
    int         t = 0;
    logic [3:0] sh [6];
    logic       ph, er;
    logic [6:0] e_seg;
    logic [5:0] e_an;
    logic       e_dp, e_fs;

    always #5 clk = ~clk;

    bcd_time_display_scan #(.SCAN_DIV(D), .SEG_ACTIVE_LOW(1'b0)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m_hr(dg[5]), .i_l_hr(dg[4]), .i_m_min(dg[3]), .i_l_min(dg[2]),
        .i_m_sec(dg[1]), .i_l_sec(dg[0]), .i_blank_lz(blank_lz),
        .o_seg(seg), .o_an(an), .o_dp(dp), .o_frame_start(fs), .o_err(err)
    );

    bcd_time_display_scan #(.SCAN_DIV(D), .SEG_ACTIVE_LOW(1'b1)) dut_n (
        .i_clk(clk), .i_rst(rst),
        .i_m_hr(dg[5]), .i_l_hr(dg[4]), .i_m_min(dg[3]), .i_l_min(dg[2]),
        .i_m_sec(dg[1]), .i_l_sec(dg[0]), .i_blank_lz(blank_lz),
        .o_seg(seg_n), .o_an(an_n), .o_dp(dp_n), .o_frame_start(fs_n), .o_err(err_n)
    );

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        dg[5] = 4'(h / 10); dg[4] = 4'(h % 10);
        dg[3] = 4'(m / 10); dg[2] = 4'(m % 10);
        dg[1] = 4'(s / 10); dg[0] = 4'(s % 10);
    endtask

    // Edge t after reset release: slots last D edges, first display at t=D+1, snapshots at t=D+k*F.
    task automatic step();
        int n, s;
        @(posedge clk);
        if (!rst) begin
            t = 0; ph = 1'b1; er = 1'b0;
            for (int k = 0; k < 6; k++) sh[k] = 4'd0;
            e_seg = '0; e_an = '0; e_dp = 1'b0; e_fs = 1'b0;
        end else begin
            t++;
            if (t <= D) begin
                e_seg = '0; e_an = '0; e_dp = 1'b0; e_fs = 1'b0;
            end else begin
                n = (t - D - 1) / D;
                s = n % 6;
                e_seg = (s == 5 && blank_lz && sh[5] == 4'd0) ? 7'd0 : seg_tab[sh[s]];
                e_an  = 6'(1 << s);
                e_dp  = ph && (s == 2 || s == 4);
                e_fs  = ((t - D - 1) % F) == 0;
            end
            if (t >= D && ((t - D) % F) == 0) begin
                for (int k = 0; k < 6; k++) if (dg[k] > 4'd9) er = 1'b1;
                if (dg[0] != sh[0]) ph = ~ph;
                for (int k = 0; k < 6; k++) sh[k] = dg[k];
            end
        end
        #1;
        check("seg", seg, e_seg);
        check("an", {1'b0, an}, {1'b0, e_an});
        check("dp", {6'd0, dp}, {6'd0, e_dp});
        check("frame_start", {6'd0, fs}, {6'd0, e_fs});
        check("err", {6'd0, err}, {6'd0, er});
        check("seg_n", seg_n, ~e_seg);
        check("an_n", {1'b0, an_n}, {1'b0, ~e_an});
        check("dp_n", {6'd0, dp_n}, {6'd0, ~e_dp});
        check("frame_start_n", {6'd0, fs_n}, {6'd0, e_fs});
        check("err_n", {6'd0, err_n}, {6'd0, er});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic to_frame_start();
        for (int i = 0; i < 3 * F && !e_fs; i++) step();
        check("reach_frame", {6'd0, e_fs}, 7'd1);
    endtask

    initial begin
        set_time(12, 34, 56);
        run(2);
        check("rst_seg_n", seg_n, 7'b1111111);
        check("rst_an_n", {1'b0, an_n}, 7'b0111111);
        rst = 1'b1;
        run(5);
        check("edge5_an", {1'b0, an}, 7'b0000001);
        check("edge5_seg", seg, 7'b1111101);
        check("edge5_fs", {6'd0, fs}, 7'd1);
        check("edge5_an_n", {1'b0, an_n}, 7'b0111110);
        check("edge5_seg_n", seg_n, 7'b0000010);
        run(2 * F);

        set_time(9, 15, 0);
        blank_lz = 1'b1;
        run(3 * F);
        blank_lz = 1'b0;
        run(2 * F);

        for (int r = 0; r < 2; r++) begin
            to_frame_start();
            dg[0] = dg[0] + 4'd1;
            run(2 * F);
        end

        dg[2] = 4'hC;
        run(F);
        dg[2] = 4'h3;
        run(2 * F);
        check("err_sticky", {6'd0, err}, 7'd1);

        for (int i = 0; i < 3 * F && e_an != 6'b001000; i++) step();
        rst = 1'b0;
        step();
        check("midrst_err", {6'd0, err}, 7'd0);
        rst = 1'b1;
        run(2 * F);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0)
                dg[$urandom_range(0, 5)] = ($urandom_range(0, 9) == 0) ?
                    4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 29) == 0) dg[5] = 4'd0;
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            rst = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
